// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, scheduler state type and Hamming [7,4] reference encoder
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CW_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    // codeword[k-1] holds Hamming position k: {d3,d2,d1,p4,d0,p2,p1}
    function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/hamming_enc_scheduler_if.sv
// rtl/hamming_enc_scheduler_if.sv - requester and result handshake bundle for the encoder scheduler
interface hamming_enc_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import hamming_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [CW_W-1:0]           out_codeword;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_codeword,
        input  out_id
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_codeword,
        output out_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching upward from ptr with wrap
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] sum;
    logic           found;

    // One extra bit on sum so ptr+k never overflows before the modulo wrap.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            if (!found && req[sum[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = sum[IDX_W-1:0];
            end
        end
    end

    assign any_req = |req;
    assign grant   = (enable && found) ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/hamming_enc_scheduler.sv
// rtl/hamming_enc_scheduler.sv - shares one Hamming [7,4] encoder among NUM_REQ requesters
// Optional encoder cross-check enabled by defining HAMMING_SCHED_CHECK_EN.
module hamming_enc_scheduler
    import hamming_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ENC_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_enc_scheduler_if.slave bus,
    output logic [DATA_W-1:0]     enc_data,
    input  logic [CW_W-1:0]       enc_codeword,
    output logic                  chk_err
);

    localparam int              ID_W     = $clog2(NUM_REQ);
    localparam int              CNT_W    = 3;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic [CW_W-1:0]  out_codeword_r;
    logic [ID_W-1:0]  out_id_r;
    logic             out_valid_r;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_req;

    // Gated by rst so no requester sees an accept strobe while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .enable    ((state == IDLE) && !rst),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign bus.req_ready    = grant;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_codeword = out_codeword_r;
    assign bus.out_id       = out_id_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            enc_data       <= '0;
            out_codeword_r <= '0;
            out_id_r       <= '0;
            out_valid_r    <= 1'b0;
            rr_ptr         <= '0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        enc_data <= bus.req_data[{grant_idx, 2'b00} +: DATA_W];
                        out_id_r <= grant_idx;
                        rr_ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                        wait_cnt <= CNT_W'(ENC_LATENCY);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter starts at ENC_LATENCY, so WAIT spans ENC_LATENCY+1 cycles.
                    if (wait_cnt == '0) begin
                        out_codeword_r <= enc_codeword;
                        out_valid_r    <= 1'b1;
                        state          <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HAMMING_SCHED_CHECK_EN
    logic chk_err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_r <= 1'b0;
        end else if ((state == WAIT) && (wait_cnt == '0) &&
                     (enc_codeword != hamming74_encode(enc_data))) begin
            chk_err_r <= 1'b1;
        end
    end

    assign chk_err = chk_err_r;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_enc_scheduler.sv
// tb/tb_hamming_enc_scheduler.sv - directed self-checking bench for hamming_enc_scheduler
module tb_hamming_enc_scheduler;
    import hamming_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int ENC_LATENCY = 1;
`ifdef HAMMING_SCHED_CHECK_EN
    localparam logic CHK_EXP = 1'b1;
`else
    localparam logic CHK_EXP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] enc_data;
    logic [6:0] enc_codeword;
    logic       chk_err;
    logic       fault_en;

    int checks = 0;
    int errors = 0;

    logic [6:0] cw_tab [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
    logic [3:0] nib_tab [4] = '{4'h4, 4'h9, 4'h6, 4'hE};

    hamming_enc_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    hamming_enc_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .ENC_LATENCY (ENC_LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .enc_data     (enc_data),
        .enc_codeword (enc_codeword),
        .chk_err      (chk_err)
    );

    // One-cycle encoder model; fault_en corrupts bit 0 for data 4'b0011.
    always_ff @(posedge clk) begin
        enc_codeword <= hamming74_encode(enc_data) |
                        (((fault_en == 1'b1) && (enc_data == 4'b0011)) ? 7'h01 : 7'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input logic [3:0] vmask, input int g, input logic [3:0] nib,
                         input logic [6:0] exp_cw);
        int edges;
        @(posedge clk); #1;
        bus.req_data[4*g +: 4] = nib;
        bus.req_valid = vmask;
        @(negedge clk);
        check("grant", bus.req_ready, 4'b1 << g);
        @(posedge clk); #1;
        bus.req_valid = '0;
        edges = 1;
        @(negedge clk);
        check("ready_pulse", bus.req_ready, 0);
        check("enc_data", enc_data, nib);
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", edges, ENC_LATENCY + 2);
        check("enc_hold", enc_data, nib);
        check("codeword", bus.out_codeword, exp_cw);
        check("out_id", bus.out_id, g);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        rst           = 1'b1;
        fault_en      = 1'b0;
        bus.req_valid = 4'b0100;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;

        // Reset state, with a request pending that must not be strobed
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_cw", bus.out_codeword, 0);
        check("rst_out_id", bus.out_id, 0);
        check("rst_enc_data", enc_data, 0);
        check("rst_chk_err", chk_err, 0);
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single requester, two nibbles
        serve(4'b0100, 2, 4'b0011, 7'h1E);
        serve(4'b0100, 2, 4'b0101, 7'h2D);

        // Fresh reset, then all requesters continuously valid
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_data  = {nib_tab[3], nib_tab[2], nib_tab[1], nib_tab[0]};
        bus.req_valid = 4'hF;
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            cyc = 0;
            while (bus.req_ready == '0 && cyc < 10) begin
                @(posedge clk); @(negedge clk);
                cyc++;
            end
            check("rr_grant", bus.req_ready, 4'b1 << (n % 4));
            if (n > 0) check("rr_gap", cyc, 0);
            cyc = 0;
            @(posedge clk); @(negedge clk);
            while (!bus.out_valid && cyc < 10) begin
                @(posedge clk); @(negedge clk);
                cyc++;
            end
            check("rr_hold_noreq", bus.req_ready, 0);
            check("rr_id", bus.out_id, n % 4);
            check("rr_cw", bus.out_codeword, cw_tab[nib_tab[n % 4]]);
            if (n < 5) begin
                @(posedge clk); @(negedge clk);
            end
        end

        // Back-pressure in HOLD; a new request must wait for IDLE
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_cw", bus.out_codeword, cw_tab[nib_tab[1]]);
            check("bp_id", bus.out_id, 1);
            check("bp_req_ready", bus.req_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_release", bus.out_valid, 0);
        check("bp_next_grant", bus.req_ready, 4'b1000);
        @(posedge clk); #1;
        bus.req_valid = '0;
        cyc = 0;
        @(negedge clk);
        while (!bus.out_valid && cyc < 10) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check("bp_next_id", bus.out_id, 3);
        check("bp_next_cw", bus.out_codeword, cw_tab[nib_tab[3]]);
        @(posedge clk); #1;

        // Every nibble through the encoder path
        for (int d = 0; d < 16; d++) begin
            serve(4'b1 << (d % 4), d % 4, 4'(d), cw_tab[d]);
        end
        check("no_false_chk", chk_err, 0);

        // Reset while in WAIT drops the in-flight nibble
        @(posedge clk); #1;
        bus.req_data[7:4] = 4'hA;
        bus.req_valid     = 4'b0010;
        @(negedge clk);
        check("mid_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        bus.req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_enc_data", enc_data, 0);
        check("mid_out_id", bus.out_id, 0);
        check("mid_out_cw", bus.out_codeword, 0);
        check("mid_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_no_valid", bus.out_valid, 0);
        end
        serve(4'b1001, 0, 4'h8, 7'h4B);

        // Faulty encoder output for 4'b0011
        fault_en = 1'b1;
        serve(4'b0100, 2, 4'b0011, 7'h1F);
        check("chk_err_set", chk_err, CHK_EXP);
        fault_en = 1'b0;
        serve(4'b0100, 2, 4'b0101, 7'h2D);
        check("chk_err_sticky", chk_err, CHK_EXP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
